// File: rtl/ir_transmitter.sv
// Pulse-width-coded IR frame transmitter: start mark, then per bit a space plus a short (0) or long (1) mark, LSB first.
// Optional 38 kHz-style carrier on ir_led is enabled by defining IR_TX_CARRIER_EN.
module ir_transmitter #(
    parameter int BASE_PULSE_WIDTH = 30000,
    parameter int DATA_BITS        = 12,
    parameter int GAP_UNITS        = 4
`ifdef IR_TX_CARRIER_EN
    ,
    parameter int CARRIER_HALF     = 658
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 send,
    output logic                 busy,
    output logic                 done,
    output logic                 ir_out
`ifdef IR_TX_CARRIER_EN
    ,
    output logic                 ir_led
`endif
);

    localparam int MAX_UNITS = (GAP_UNITS > 4) ? GAP_UNITS : 4;
    localparam int CNT_W     = $clog2(MAX_UNITS * BASE_PULSE_WIDTH + 1);
    localparam int BIT_W     = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] START_LEN = CNT_W'(4 * BASE_PULSE_WIDTH);
    localparam logic [CNT_W-1:0] UNIT_LEN  = CNT_W'(BASE_PULSE_WIDTH);
    localparam logic [CNT_W-1:0] LONG_LEN  = CNT_W'(2 * BASE_PULSE_WIDTH);
    localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(GAP_UNITS * BASE_PULSE_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SPACE,
        S_MARK,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ir;
    logic                 w_cnt_last;

    // The counter holds the cycles remaining in the current phase, including this one.
    assign w_cnt_last = (r_cnt <= CNT_W'(1));

    // NOTE: all state lives in one clocked block and uses non-blocking assignments so
    // every register samples pre-edge values; the reset branch is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ir      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ir   <= 1'b1;
                    r_busy <= 1'b0;
                    if (send) begin
                        r_shift   <= data;
                        r_bit_cnt <= '0;
                        r_cnt     <= START_LEN;
                        r_state   <= S_START;
                        r_ir      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_cnt_last) begin
                        r_state <= S_SPACE;
                        r_cnt   <= UNIT_LEN;
                        r_ir    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_SPACE: begin
                    if (w_cnt_last) begin
                        r_state <= S_MARK;
                        r_cnt   <= r_shift[0] ? LONG_LEN : UNIT_LEN;
                        r_ir    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_MARK: begin
                    if (w_cnt_last) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        r_ir      <= 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= S_GAP;
                            r_cnt   <= GAP_LEN;
                        end else begin
                            r_state <= S_SPACE;
                            r_cnt   <= UNIT_LEN;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_cnt_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ir    <= 1'b1;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ir_out = r_ir;

`ifdef IR_TX_CARRIER_EN
    localparam int CAR_W = $clog2(CARRIER_HALF + 1);
    localparam logic [CAR_W-1:0] CAR_LEN = CAR_W'(CARRIER_HALF);

    logic             w_mark_entry;
    logic             w_in_mark;
    logic             w_mark_exit;
    logic [CAR_W-1:0] r_car_cnt;
    logic             r_led;

    // Entry conditions mirror the FSM transitions so the carrier phase restarts with every mark.
    assign w_mark_entry = ((r_state == S_IDLE) && send) || ((r_state == S_SPACE) && w_cnt_last);
    assign w_in_mark    = (r_state == S_START) || (r_state == S_MARK);
    assign w_mark_exit  = w_in_mark && w_cnt_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_car_cnt <= '0;
            r_led     <= 1'b0;
        end else if (w_mark_entry) begin
            r_car_cnt <= CAR_LEN;
            r_led     <= 1'b1;
        end else if (w_mark_exit || !w_in_mark) begin
            r_car_cnt <= '0;
            r_led     <= 1'b0;
        end else if (r_car_cnt <= CAR_W'(1)) begin
            r_car_cnt <= CAR_LEN;
            r_led     <= ~r_led;
        end else begin
            r_car_cnt <= r_car_cnt - CAR_W'(1);
        end
    end

    assign ir_led = r_led;
`endif

endmodule

// File: tb/tb_ir_transmitter.sv
// Directed self-checking bench for ir_transmitter at BASE_PULSE_WIDTH=10, GAP_UNITS=4, 12 data bits.
// Line activity is recorded as alternating run lengths and compared against hand-derived frame shapes.
module tb_ir_transmitter;

    localparam int T    = 10;
    localparam int GAPU = 4;
    localparam int NB   = 12;
    localparam int TAIL = 20;

    logic          clk;
    logic          rst;
    logic [NB-1:0] data;
    logic          send;
    logic          busy;
    logic          done;
    logic          ir_out;

    int n_checks;
    int n_pass;

    int runs[$];
    int exp_runs[$];
    int busy_cycles;
    int done_pulses;
    int done_idx;

    ir_transmitter #(
        .BASE_PULSE_WIDTH(T),
        .DATA_BITS       (NB),
        .GAP_UNITS       (GAPU)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .send  (send),
        .busy  (busy),
        .done  (done),
        .ir_out(ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line shape: start mark, then space/mark per bit, then trailing high of gap plus idle tail.
    function automatic void build_exp(input logic [NB-1:0] w, input int tail);
        exp_runs.delete();
        exp_runs.push_back(4 * T);
        for (int b = 0; b < NB; b++) begin
            exp_runs.push_back(T);
            exp_runs.push_back(w[b] ? 2 * T : T);
        end
        exp_runs.push_back(GAPU * T + tail);
    endfunction

    function automatic int exp_busy_len(input logic [NB-1:0] w);
        return 4 * T + NB * T + (NB + $countones(w)) * T + GAPU * T;
    endfunction

    task automatic send_pulse(input logic [NB-1:0] w);
        @(negedge clk);
        data = w;
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        data = ~w;
    endtask

    task automatic sample_window(input int n);
        logic cur_lvl;
        int   cur_len;
        runs.delete();
        busy_cycles = 0;
        done_pulses = 0;
        done_idx    = -1;
        cur_lvl     = 1'b1;
        cur_len     = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (done_idx < 0) done_idx = i;
            end
            if (cur_len == 0) begin
                cur_lvl = ir_out;
                cur_len = 1;
            end else if (ir_out == cur_lvl) begin
                cur_len++;
            end else begin
                runs.push_back(cur_len);
                cur_lvl = ir_out;
                cur_len = 1;
            end
        end
        runs.push_back(cur_len);
    endtask

    task automatic test_reset;
        rst  = 1'b0;
        send = 1'b0;
        data = '0;
        #1 rst = 1'b1;
        #4;
        n_checks++;
        if ({ir_out, busy, done} !== 3'b100)
            $display("FAIL reset_outputs: ir_out/busy/done got %b expected 100", {ir_out, busy, done});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ir_out, busy, done} !== 3'b100)
            $display("FAIL idle_after_reset: ir_out/busy/done got %b expected 100", {ir_out, busy, done});
        else n_pass++;
    endtask

    task automatic test_frame_format(input logic [NB-1:0] w);
        int eb;
        int bad;
        eb = exp_busy_len(w);
        build_exp(w, TAIL);
        send_pulse(w);
        sample_window(eb + TAIL);
        n_checks++;
        bad = -1;
        if (runs.size() != exp_runs.size()) bad = 999;
        else for (int i = 0; i < runs.size(); i++) if (bad < 0 && runs[i] != exp_runs[i]) bad = i;
        if (bad == 999)
            $display("FAIL frame_runs %h: run count got %0d expected %0d", w, runs.size(), exp_runs.size());
        else if (bad >= 0)
            $display("FAIL frame_runs %h: run %0d got %0d expected %0d", w, bad, runs[bad], exp_runs[bad]);
        else n_pass++;
        n_checks++;
        if (busy_cycles != eb)
            $display("FAIL busy_len %h: got %0d expected %0d", w, busy_cycles, eb);
        else n_pass++;
        n_checks++;
        if (done_pulses != 1 || done_idx != eb)
            $display("FAIL done_pulse %h: count %0d at %0d expected 1 at %0d", w, done_pulses, done_idx, eb);
        else n_pass++;
    endtask

    task automatic test_busy_ignore;
        int eb;
        int bad;
        eb = exp_busy_len(12'hF0D);
        build_exp(12'hF0D, TAIL);
        send_pulse(12'hF0D);
        fork
            sample_window(eb + TAIL);
            begin
                repeat (100) @(posedge clk);
                #1;
                data = 12'h123;
                send = 1'b1;
                @(posedge clk);
                #1;
                send = 1'b0;
            end
        join
        n_checks++;
        bad = -1;
        if (runs.size() != exp_runs.size()) bad = 999;
        else for (int i = 0; i < runs.size(); i++) if (bad < 0 && runs[i] != exp_runs[i]) bad = i;
        if (bad == 999)
            $display("FAIL ignore_runs: run count got %0d expected %0d", runs.size(), exp_runs.size());
        else if (bad >= 0)
            $display("FAIL ignore_runs: run %0d got %0d expected %0d", bad, runs[bad], exp_runs[bad]);
        else n_pass++;
        n_checks++;
        if (busy_cycles != eb || done_pulses != 1)
            $display("FAIL ignore_busy: busy %0d done %0d expected %0d and 1", busy_cycles, done_pulses, eb);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int  eb;
        bit  seen;
        eb = exp_busy_len(12'hF0D);
        @(negedge clk);
        data = 12'hF0D;
        send = 1'b1;
        seen = 1'b0;
        fork
            sample_window(2 * eb + 1 + TAIL);
            begin
                for (int i = 0; i < 2 * eb; i++) begin
                    @(negedge clk);
                    if (done) begin
                        seen = 1'b1;
                        break;
                    end
                end
                @(posedge clk);
                #1;
                send = 1'b0;
            end
        join
        n_checks++;
        if (!seen) $display("FAIL b2b_first_done: not seen within %0d cycles", 2 * eb);
        else n_pass++;
        n_checks++;
        if (runs.size() != 52)
            $display("FAIL b2b_run_count: got %0d expected 52", runs.size());
        else n_pass++;
        n_checks++;
        if (runs.size() > 26 && (runs[25] != GAPU * T + 1 || runs[26] != 4 * T))
            $display("FAIL b2b_separation: high %0d start %0d expected %0d and %0d",
                     runs[25], runs[26], GAPU * T + 1, 4 * T);
        else if (runs.size() <= 26)
            $display("FAIL b2b_separation: only %0d runs recorded", runs.size());
        else n_pass++;
        n_checks++;
        if (done_pulses != 2 || busy_cycles != 2 * eb)
            $display("FAIL b2b_done_busy: done %0d busy %0d expected 2 and %0d", done_pulses, busy_cycles, 2 * eb);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        send_pulse(12'hF0D);
        // Bit 3 mark begins 130 cycles after acceptance: 40 + (10+20) + (10+10) + (10+20) + 10.
        repeat (130) @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        n_checks++;
        if (ir_out !== 1'b0 || busy !== 1'b1)
            $display("FAIL mid_mark_line: ir_out %b busy %b expected 0 and 1", ir_out, busy);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ir_out, busy, done} !== 3'b100)
            $display("FAIL async_reset: ir_out/busy/done got %b expected 100", {ir_out, busy, done});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ir_out, busy, done} !== 3'b100)
            $display("FAIL post_reset_idle: ir_out/busy/done got %b expected 100", {ir_out, busy, done});
        else n_pass++;
        test_frame_format(12'h5A3);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_frame_format(12'hF0D);
        test_frame_format(12'h000);
        test_frame_format(12'hFFF);
        test_busy_ignore();
        test_back_to_back();
        repeat (10) @(negedge clk);
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
